// File: rtl/inst_mem_boot_ctrl.sv
// inst_mem_boot_ctrl
// Owns the instruction memory port. After reset it loads a byte-serial program
// from address 0 upward and zero-fills the rest of memory. It then hands the
// port to the fetch stage, which it guards against illegal PCs.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accept loader bytes, write M[wptr], fetch stalled
// CLEAR | zero-fill M[wptr..MEM_BYTES-1], fetch stalled
// RUN   | memory address follows pc, inst delivered combinationally

module inst_mem_boot_ctrl #(
    parameter int MEM_BYTES = 256,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload_req,
    input  logic [AW-1:0] pc,
    output logic [31:0]   inst,
    output logic          fetch_stall,
    output logic          fetch_fault,
    output logic          boot_done,
    output logic [AW-1:0] mem_address,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // One extra bit so the write pointer can represent MEM_BYTES itself.
    localparam int              WPW       = $clog2(MEM_BYTES) + 1;
    localparam logic [WPW-1:0]  LAST_ADDR = WPW'(MEM_BYTES - 1);
    localparam logic [AW-1:0]   PC_MAX    = AW'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t         state;
    logic [WPW-1:0] wptr;
    logic           fault_q;
    logic           done_q;
    logic           stall_q;
    logic           pc_legal;

    // A fetch is legal only when word aligned and the whole word lies in memory.
    assign pc_legal = (pc[1:0] == 2'b00) && (pc <= PC_MAX);

    // Sequencer: load, zero-fill, run; status flags move with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            wptr    <= '0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_valid) begin
                        wptr <= wptr + WPW'(1);
                        // Writing the top byte fills memory: treat it as last.
                        if (wptr == LAST_ADDR) begin
                            state   <= RUN;
                            done_q  <= 1'b1;
                            stall_q <= 1'b0;
                        end else if (ld_last) begin
                            state <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    wptr <= wptr + WPW'(1);
                    if (wptr == LAST_ADDR) begin
                        state   <= RUN;
                        done_q  <= 1'b1;
                        stall_q <= 1'b0;
                    end
                end
                RUN: begin
                    // Reload takes priority over recording a fault on the same cycle.
                    if (reload_req) begin
                        state   <= LOAD;
                        wptr    <= '0;
                        fault_q <= 1'b0;
                        done_q  <= 1'b0;
                        stall_q <= 1'b1;
                    end else if (!pc_legal) begin
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= LOAD;
                    wptr    <= '0;
                    fault_q <= 1'b0;
                    done_q  <= 1'b0;
                    stall_q <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_fault = fault_q;
    assign boot_done   = done_q;
    assign fetch_stall = stall_q;

    // Memory port mux and instruction path, selected by state.
    always_comb begin
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        mem_address = '0;
        inst        = 32'h0;
        case (state)
            LOAD: begin
                ld_ready    = 1'b1;
                mem_address = AW'(wptr);
                mem_wdata   = ld_data;
                mem_we      = ld_valid;
            end
            CLEAR: begin
                mem_address = AW'(wptr);
                mem_we      = 1'b1;
            end
            RUN: begin
                mem_address = pc;
                // Illegal fetches get a nop (sll $0,$0,0) rather than stale data.
                inst = pc_legal ? mem_rdata : 32'h0;
            end
            default: begin
                ld_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_mem_boot_ctrl.sv
// Directed bench for inst_mem_boot_ctrl with a byte-wide memory model.
module tb_inst_mem_boot_ctrl;

    localparam int MEM_BYTES = 256;
    localparam int AW        = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload_req;
    logic [AW-1:0] pc;
    logic [31:0]   inst;
    logic          fetch_stall;
    logic          fetch_fault;
    logic          boot_done;
    logic [AW-1:0] mem_address;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [MEM_BYTES];
    logic [7:0] ra;

    inst_mem_boot_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .reload_req  (reload_req),
        .pc          (pc),
        .inst        (inst),
        .fetch_stall (fetch_stall),
        .fetch_fault (fetch_fault),
        .boot_done   (boot_done),
        .mem_address (mem_address),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-write, big-endian word-read memory.
    assign ra        = mem_address[7:0];
    assign mem_rdata = {mem[ra], mem[8'(ra + 8'd1)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd3)]};

    always @(posedge clk) begin
        if (mem_we) mem[mem_address[7:0]] <= mem_wdata;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Counts edges until boot_done, also counting cycles that broke the stall rules.
    task automatic wait_boot(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (!boot_done && n < 1000) begin
            if (!fetch_stall || inst != 32'h0 || ld_ready) bad++;
            tick();
            n++;
        end
    endtask

    task automatic pulse_reload();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
    endtask

    logic [31:0] prog [8] = '{32'h8FE10001, 32'h8FE20002, 32'h00221820, 32'h00000000,
                              32'h1000FFFF, 32'h00000000, 32'h00000000, 32'hAFE30003};

    initial begin
        int n;
        int bad;
        logic [31:0] w;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h5A;
        rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        reload_req = 1'b0; pc = '0;
        tick(); tick();

        // Reset state
        check_val("rst_stall", fetch_stall, 1);
        check_val("rst_done",  boot_done, 0);
        check_val("rst_fault", fetch_fault, 0);
        check_val("rst_ready", ld_ready, 1);
        check_val("rst_addr",  mem_address, 0);
        rst_n = 1'b1;
        tick();

        // 32-byte program, ld_valid held high
        for (int i = 0; i < 32; i++) begin
            w = prog[i / 4];
            send(w[31 - 8 * (i % 4) -: 8], i == 31);
        end
        check_val("sum_clr_addr", mem_address, 32);
        check_val("sum_clr_we",   mem_we, 1);
        check_val("sum_clr_wd",   mem_wdata, 0);
        check_val("sum_clr_rdy",  ld_ready, 0);
        wait_boot(n, bad);
        check_val("sum_clr_cycles", n, 224);
        check_val("sum_clr_bad",    bad, 0);
        check_val("sum_stall", fetch_stall, 0);
        check_val("sum_we",    mem_we, 0);
        pc = 0;  #1 check_val("sum_pc0",  inst, 32'h8FE10001);
        pc = 28; #1 check_val("sum_pc28", inst, 32'hAFE30003);
        pc = 8;  #1 check_val("sum_pc8",  inst, 32'h00221820);
        pc = 32; #1 check_val("sum_pc32", inst, 32'h0);
        check_val("sum_pc32_addr", mem_address, 32);
        pc = 0;
        tick();
        check_val("sum_nofault", fetch_fault, 0);

        // Illegal fetch: out of range, then misaligned
        pc = 256; #1 check_val("ill_256_inst", inst, 0);
        tick();
        check_val("ill_256_fault", fetch_fault, 1);
        pc = 2; #1 check_val("ill_2_inst", inst, 0);
        tick();
        pc = 0; tick();
        check_val("ill_sticky", fetch_fault, 1);
        pulse_reload();
        check_val("rl_fault", fetch_fault, 0);
        check_val("rl_done",  boot_done, 0);
        check_val("rl_stall", fetch_stall, 1);

        // Loader backpressure: valid every other cycle
        for (int i = 0; i < 8; i++) begin
            send(8'(i + 1), i == 7);
            if (i < 7) begin
                ld_valid = 1'b0; ld_data = 8'hEE; ld_last = 1'b1;
                #1 check_val("bp_addr", mem_address, i + 1);
                check_val("bp_nowe", mem_we, 0);
                tick();
                check_val("bp_hold", mem_address, i + 1);
                ld_last = 1'b0;
            end
        end
        wait_boot(n, bad);
        check_val("bp_clr_cycles", n, 248);
        pc = 4; #1 check_val("bp_pc4", inst, 32'h05060708);
        pc = 0; #1 check_val("bp_pc0", inst, 32'h01020304);

        // Reload on the same cycle as an illegal pc: reload wins
        pc = 3; pulse_reload();
        check_val("rlill_fault", fetch_fault, 0);
        check_val("rlill_done",  boot_done, 0);
        check_val("rlill_addr",  mem_address, 0);
        check_val("rlill_inst",  inst, 0);
        pc = 0;

        // Full memory, no ld_last: LOAD goes straight to RUN
        for (int i = 0; i < MEM_BYTES; i++) send(8'(i), 1'b0);
        check_val("full_done",  boot_done, 1);
        check_val("full_ready", ld_ready, 0);
        check_val("full_stall", fetch_stall, 0);
        pc = 252; #1 check_val("full_pc252", inst, 32'hFCFDFEFF);
        pc = 253; #1 check_val("full_pc253", inst, 0);
        tick();
        check_val("full_fault", fetch_fault, 1);
        pc = 0;

        // Reset mid-load
        pulse_reload();
        for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), 1'b0);
        check_val("rml_addr10", mem_address, 10);
        rst_n = 1'b0;
        #1 check_val("rml_async_addr", mem_address, 0);
        check_val("rml_async_done", boot_done, 0);
        tick();
        rst_n = 1'b1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        wait_boot(n, bad);
        check_val("rml_clr_cycles", n, 252);
        pc = 0; #1 check_val("rml_pc0", inst, 32'h11223344);
        bad = 0;
        for (int a = 4; a < MEM_BYTES; a += 4) begin
            pc = a; #1 if (inst != 32'h0) bad++;
        end
        check_val("rml_zero_words", bad, 0);
        pc = 0;

        // Reload and load 4 bytes; stall must cover LOAD and CLEAR
        pulse_reload();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (!fetch_stall || boot_done) bad++;
            send(8'(8'hC0 + i), i == 3);
        end
        check_val("rl4_load_stall", bad, 0);
        wait_boot(n, bad);
        check_val("rl4_clr_cycles", n, 252);
        check_val("rl4_clr_bad",    bad, 0);
        check_val("rl4_done",       boot_done, 1);
        pc = 0; #1 check_val("rl4_pc0", inst, 32'hC0C1C2C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
